// File: rtl/vga_timing_pkg.sv
// Shared display-mode constants for the VGA timing generator.
// Defaults describe 1280x1024 @ 60 Hz (108 MHz pixel clock).
package vga_timing_pkg;

    localparam int X_W = 11;
    localparam int Y_W = 10;

    localparam int DEF_PIX_CLK_KHZ = 108000;

    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_H_FP     = 48;
    localparam int DEF_H_SYNC   = 112;
    localparam int DEF_H_BP     = 248;

    localparam int DEF_V_ACTIVE = 1024;
    localparam int DEF_V_FP     = 1;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BP     = 38;

    localparam bit DEF_SYNC_POL = 1'b1;

    function automatic int span_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_H_TOTAL = span_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = span_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/mod_counter.sv
// Wrap counter 0..MOD-1 with increment enable; carry is high on the
// increment that wraps back to zero.
module mod_counter #(
    parameter int W   = 11,
    parameter int MOD = 1688
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         carry
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    assign carry = inc && (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= carry ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running h/v counters with registered
// position, active-region and sync outputs, all one cycle behind the counters.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = DEF_SYNC_POL
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           valid,
    output logic           hsync,
    output logic           vsync,
    output logic           frame_start,
    output logic           line_end
);

    localparam int H_TOTAL    = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL    = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW         = cnt_width(H_TOTAL);
    localparam int VW         = cnt_width(V_TOTAL);
    localparam int H_SYNC_BEG = H_ACTIVE + H_FP;
    localparam int H_SYNC_END = H_SYNC_BEG + H_SYNC;
    localparam int V_SYNC_BEG = V_ACTIVE + V_FP;
    localparam int V_SYNC_END = V_SYNC_BEG + V_SYNC;

    logic          rst_q;
    logic          run;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          h_wrap;
    logic          v_carry_unused;
    logic [31:0]   h_ext;
    logic [31:0]   v_ext;
    logic          valid_d;
    logic          hsync_d;
    logic          vsync_d;
    logic          frame_start_d;
    logic          line_end_d;

    // Single release flop: the first edge after release only arms it, so
    // counting begins on the second edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_q <= 1'b0;
        end else begin
            rst_q <= 1'b1;
        end
    end

    assign run = en && rst_q;

    mod_counter #(.W(HW), .MOD(H_TOTAL)) u_hcnt (
        .clk   (clk),
        .reset (reset),
        .inc   (run),
        .cnt   (hcnt),
        .carry (h_wrap)
    );

    mod_counter #(.W(VW), .MOD(V_TOTAL)) u_vcnt (
        .clk   (clk),
        .reset (reset),
        .inc   (h_wrap),
        .cnt   (vcnt),
        .carry (v_carry_unused)
    );

    // Region decode in 32 bits so an end bound equal to 2**HW cannot alias.
    assign h_ext         = 32'(hcnt);
    assign v_ext         = 32'(vcnt);
    assign valid_d       = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
    assign hsync_d       = ((h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END)) ? SYNC_POL : !SYNC_POL;
    assign vsync_d       = ((v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END)) ? SYNC_POL : !SYNC_POL;
    assign frame_start_d = (hcnt == '0) && (vcnt == '0);
    assign line_end_d    = (h_ext == H_TOTAL - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x           <= '0;
            y           <= '0;
            valid       <= 1'b0;
            hsync       <= !SYNC_POL;
            vsync       <= !SYNC_POL;
            frame_start <= 1'b0;
            line_end    <= 1'b0;
        end else if (run) begin
            x           <= X_W'(hcnt);
            y           <= Y_W'(vcnt);
            valid       <= valid_d;
            hsync       <= hsync_d;
            vsync       <= vsync_d;
            frame_start <= frame_start_d;
            line_end    <= line_end_d;
        end else begin
            frame_start <= 1'b0;
            line_end    <= 1'b0;
        end
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL provide parameter H_ACTIVE, default 1280, visible pixels per line.
REQ-002 The block SHALL provide parameters H_FP, H_SYNC, H_BP, defaults 48, 112, 248, horizontal front porch, sync and back porch in pixels.
REQ-003 The block SHALL provide parameter V_ACTIVE, default 1024, visible lines per frame.
REQ-004 The block SHALL provide parameters V_FP, V_SYNC, V_BP, defaults 1, 3, 38, vertical front porch, sync and back porch in lines.
REQ-005 The block SHALL provide parameter SYNC_POL, default 1, where 1 means the sync pulses are active-high.
REQ-006 clk  input  1  pixel clock; the only clock in the block.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 en  input  1  pixel enable; the counters advance only on cycles where en=1.
REQ-009 x  output  11  horizontal pixel index, 0..H_ACTIVE-1 while valid=1.
REQ-010 y  output  10  vertical line index, 0..V_ACTIVE-1 while valid=1.
REQ-011 valid  output  1  high when (x,y) lies in the active region.
REQ-012 hsync  output  1  horizontal sync pulse, polarity set by SYNC_POL.
REQ-013 vsync  output  1  vertical sync pulse, polarity set by SYNC_POL.
REQ-014 frame_start  output  1  single-cycle pulse on the first active pixel of each frame (x=0, y=0, valid=1).
REQ-015 line_end  output  1  single-cycle pulse on the last pixel (of H_TOTAL) of every line.

Function
REQ-016 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP (default 1688), and V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP (default 1066).
REQ-017 The internal counter hcnt SHALL count 0..H_TOTAL-1 on en=1 cycles and then wrap to 0.
REQ-018 The internal counter vcnt SHALL increment only when hcnt wraps, and SHALL wrap from V_TOTAL-1 to 0.
REQ-019 Simultaneous wrap of hcnt and vcnt SHALL take both counters to 0 on the same cycle.
REQ-020 With en=0, the counters and all outputs SHALL hold their values, and frame_start and line_end SHALL be forced to 0.
REQ-021 The horizontal regions SHALL be, in order: active [0,H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch; the vertical regions SHALL follow the same order using the V_ parameters.
REQ-022 All outputs SHALL be registered, and each SHALL reflect the counter state with exactly 1 cycle of latency, so all outputs are mutually aligned.
REQ-023 While valid=0, x SHALL equal hcnt truncated to 11 bits and y SHALL equal vcnt truncated to 10 bits; downstream logic SHALL qualify x and y with valid.
REQ-024 The vsync transition SHALL coincide with the hcnt=0 boundary of the first and last-plus-one V_SYNC lines.
REQ-025 All region comparisons SHALL be evaluated on the counter values; no output SHALL depend combinationally on en.

Reset
REQ-026 While reset=0, hcnt and vcnt SHALL be 0, x=0, y=0, valid=0, frame_start=0, line_end=0, and hsync and vsync SHALL be at their inactive level.
REQ-027 Reset assertion SHALL take effect asynchronously at any point in a frame, and deassertion SHALL be synchronised so that counting starts on the second clk edge after release.
REQ-028 After reset release with en=1 held, the first output cycle SHALL show x=0, y=0, valid=1, frame_start=1.

Structure
REQ-029 The default timing constants and the H_TOTAL/V_TOTAL derivation SHALL reside in the shared package vga_timing_pkg, alongside the other display-mode constants.
REQ-030 The block SHALL contain one sub-module, mod_counter (a parameterised wrap counter with enable and carry-out), instantiated once for hcnt and once for vcnt.

Verification
REQ-031 Bench: reset release, en=1 -> cycle 1 shows x=0, y=0, valid=1, frame_start=1; hsync/vsync inactive.
REQ-032 Bench: run one full line -> valid high exactly 1280 cycles; hsync active exactly 112 cycles starting 1328 cycles after line start; line_end pulses once every 1688 cycles.
REQ-033 Bench: run one full frame -> vsync active for 3x1688 cycles starting at line 1025; frame_start period exactly 1688x1066 = 1,799,408 cycles.
REQ-034 Bench: toggle en at 50% random duty -> output sequence identical to en=1 run after removing en=0 cycles; no pulse on an en=0 cycle.
REQ-035 Bench: assert reset at hcnt=700, vcnt=500 -> all outputs take reset values immediately; after release, the frame restarts at (0,0).
REQ-036 Bench: SYNC_POL=0, small parameters (H 8/2/2/2, V 4/1/1/1) -> inverted sync levels; H_TOTAL=14 and V_TOTAL=7 verified against a reference model.
